// File: rtl/ama_riscv_pipe_ctrl_if.sv
// Control/status bundle between the RISC-V pipeline datapath and its hazard controller.
interface ama_riscv_pipe_ctrl_if;
    logic        imem_rsp_valid;
    logic        ex_load;
    logic [4:0]  ex_rd_addr;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic        ex_flush_req;
    logic        pc_we;
    logic        if_dec_we;
    logic        dec_bubble;
    logic        if_dec_flush;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport slave (
        input  imem_rsp_valid, ex_load, ex_rd_addr, dec_rs1_addr, dec_rs2_addr,
               dec_rs1_used, dec_rs2_used, ex_flush_req,
        output pc_we, if_dec_we, dec_bubble, if_dec_flush, state, stall_cnt, flush_cnt
    );

    modport master (
        output imem_rsp_valid, ex_load, ex_rd_addr, dec_rs1_addr, dec_rs2_addr,
               dec_rs1_used, dec_rs2_used, ex_flush_req,
        input  pc_we, if_dec_we, dec_bubble, if_dec_flush, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline hazard controller: reset hold, load-use stall, imem stall and branch flush.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module ama_riscv_pipe_ctrl #(
    parameter int unsigned RST_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ama_riscv_pipe_ctrl_if.slave  pif
);

    typedef enum logic [1:0] {
        ST_RST        = 2'd0,
        ST_STEADY     = 2'd1,
        ST_STALL_FLOW = 2'd2,
        ST_STALL_IMEM = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       load_use;
    logic       pc_we, if_dec_we, dec_bubble, if_dec_flush;

    assign load_use = pif.ex_load && (pif.ex_rd_addr != 5'd0) &&
                      ((pif.dec_rs1_used && (pif.dec_rs1_addr == pif.ex_rd_addr)) ||
                       (pif.dec_rs2_used && (pif.dec_rs2_addr == pif.ex_rd_addr)));

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        pc_we        = 1'b0;
        if_dec_we    = 1'b0;
        dec_bubble   = 1'b1;
        if_dec_flush = 1'b0;
        case (state_q)
            ST_RST: begin
                hold_cnt_d = hold_cnt_q + 4'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = 4'd0;
                    state_d    = pif.imem_rsp_valid ? ST_STEADY : ST_STALL_IMEM;
                end
            end
            default: begin
                if (pif.ex_flush_req) begin
                    pc_we        = 1'b1;
                    if_dec_flush = 1'b1;
                    state_d      = pif.imem_rsp_valid ? ST_STEADY : ST_STALL_IMEM;
                end else if ((state_q == ST_STEADY) && load_use) begin
                    // Load-use is only acted on from STEADY; the stalled pair is forwarded next cycle
                    state_d = ST_STALL_FLOW;
                end else if (!pif.imem_rsp_valid) begin
                    state_d = ST_STALL_IMEM;
                end else begin
                    pc_we      = 1'b1;
                    if_dec_we  = 1'b1;
                    dec_bubble = 1'b0;
                    state_d    = ST_STEADY;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RST;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign pif.pc_we        = pc_we;
    assign pif.if_dec_we    = if_dec_we;
    assign pif.dec_bubble   = dec_bubble;
    assign pif.if_dec_flush = if_dec_flush;
    assign pif.state        = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (dec_bubble && (state_q != ST_RST) && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (if_dec_flush && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pif.stall_cnt = stall_cnt_q;
    assign pif.flush_cnt = flush_cnt_q;
`else
    assign pif.stall_cnt = 32'd0;
    assign pif.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Randomized scoreboard bench for ama_riscv_pipe_ctrl against a rule-level reference model.
module tb_ama_riscv_pipe_ctrl;

    localparam int RST_HOLD = 2;

    typedef struct packed {
        logic        pc_we;
        logic        if_dec_we;
        logic        dec_bubble;
        logic        if_dec_flush;
        logic [1:0]  state;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    ama_riscv_pipe_ctrl_if pif ();

    ama_riscv_pipe_ctrl #(.RST_HOLD(RST_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: which pipeline phase we are in, written as plain rules.
    // Phase codes are the externally visible state numbers.
    int          mode;
    int          rst_cycles;
    longint      m_stall;
    longint      m_flush;

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic cyc(input logic r, input logic imem, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic fl);
        exp_t e;
        bit   hazard;
        int   nxt;
        @(posedge clk);
        #1;
        rst                = r;
        pif.imem_rsp_valid = imem;
        pif.ex_load        = ld;
        pif.ex_rd_addr     = rd;
        pif.dec_rs1_addr   = rs1;
        pif.dec_rs2_addr   = rs2;
        pif.dec_rs1_used   = u1;
        pif.dec_rs2_used   = u2;
        pif.ex_flush_req   = fl;
        if (!r) begin
            mode = 0; rst_cycles = 0; m_stall = 0; m_flush = 0;
            e = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0};
            sb_q.push_back(e);
            return;
        end
        hazard = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        e.state     = 2'(mode);
        e.stall_cnt = 32'd0;
        e.flush_cnt = 32'd0;
`ifdef PIPE_CTRL_PERF_EN
        e.stall_cnt = sat32(m_stall);
        e.flush_cnt = sat32(m_flush);
`endif
        // default: a bubble with nothing advancing
        {e.pc_we, e.if_dec_we, e.dec_bubble, e.if_dec_flush} = 4'b0010;
        nxt = mode;
        if (mode == 0) begin
            rst_cycles++;
            if (rst_cycles >= RST_HOLD) nxt = imem ? 1 : 3;
        end else if (fl) begin
            {e.pc_we, e.if_dec_we, e.dec_bubble, e.if_dec_flush} = 4'b1011;
            nxt = imem ? 1 : 3;
        end else if (mode == 1 && hazard) begin
            nxt = 2;
        end else if (!imem) begin
            nxt = 3;
        end else begin
            {e.pc_we, e.if_dec_we, e.dec_bubble, e.if_dec_flush} = 4'b1100;
            nxt = 1;
        end
        if (mode != 0 && e.dec_bubble) m_stall++;
        if (e.if_dec_flush) m_flush++;
        mode = nxt;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT against the queued expectation every cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e, a;
            e = sb_q.pop_front();
            a = '{pif.pc_we, pif.if_dec_we, pif.dec_bubble, pif.if_dec_flush, pif.state,
                  pif.stall_cnt, pif.flush_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctl t=%0t got pc_we=%b ifd_we=%b bub=%b fl=%b st=%0d sc=%0d fc=%0d exp pc_we=%b ifd_we=%b bub=%b fl=%b st=%0d sc=%0d fc=%0d",
                         $time, a.pc_we, a.if_dec_we, a.dec_bubble, a.if_dec_flush, a.state,
                         a.stall_cnt, a.flush_cnt, e.pc_we, e.if_dec_we, e.dec_bubble,
                         e.if_dec_flush, e.state, e.stall_cnt, e.flush_cnt);
            end
            if (pif.pc_we && pif.if_dec_we && pif.dec_bubble) begin
                errors++;
                $display("FAIL illegal_combo pc_we=1 if_dec_we=1 dec_bubble=1 at t=%0t", $time);
            end
        end
    end

    initial begin
        pif.imem_rsp_valid = 1'b1;
        pif.ex_load        = 1'b0;
        pif.ex_rd_addr     = 5'd0;
        pif.dec_rs1_addr   = 5'd0;
        pif.dec_rs2_addr   = 5'd0;
        pif.dec_rs1_used   = 1'b0;
        pif.dec_rs2_used   = 1'b0;
        pif.ex_flush_req   = 1'b0;
        mode = 0; rst_cycles = 0; m_stall = 0; m_flush = 0;

        // reset, release, RST for RST_HOLD cycles then STEADY
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // load-use on rs1, then forwarding cycle with EX holding the bubble
        cyc(1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // same with rd=x0: no stall; also unused-source match: no stall
        cyc(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
        // rs2 hazard
        cyc(1'b1, 1'b1, 1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b0);
        idle(1);
        // imem starvation for 3 cycles
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // flush beats load-use and imem miss
        cyc(1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        // reset in the middle of STALL_IMEM, then restart sequence
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // randomized traffic; EX holds a bubble during the forwarding cycle
        for (int i = 0; i < 2000; i++) begin
            logic r, imem, ld, u1, u2, fl;
            logic [4:0] rd, rs1, rs2;
            r    = ($urandom_range(0, 199) != 0);
            imem = ($urandom_range(0, 4) != 0);
            ld   = ($urandom_range(0, 2) == 0) && (mode != 2);
            rd   = 5'($urandom_range(0, 3));
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 9) == 0);
            cyc(r, imem, ld, rd, rs1, rs2, u1, u2, fl);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
